// File: rtl/uart_pkg.sv
// Constants and types shared by the UART transmitter and receiver.
// Bit timing values are kept here so both ends agree on the baud divider.
package uart_pkg;

  localparam int BAUD_END_SIM      = 56;
  localparam int BAUD_END_9600_50M = 5208;
  localparam int DATA_BITS         = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
// Storage is a plain array with a registered read port; a full FIFO still takes a write when it pops that cycle.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [DW-1:0] din,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dout_reg;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [AW:0]   count_reg, count_next;
  logic          wr_ok;
  logic          rd_ok;

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign dout  = dout_reg;

  assign wr_ok = wr_en && (!full || rd_en);
  assign rd_ok = rd_en && !empty;

  // Read-before-write: a same-cycle write to the head slot returns the old head.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_reg] <= din;
    end
    if (rd_ok) begin
      dout_reg <= mem[rd_ptr_reg];
    end
  end

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (wr_ok) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (rd_ok) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffers byte strobes in a small FIFO and serialises them LSB first.
// All outputs are registered; line drive lags the FSM state by one clock.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_END   = BAUD_END_SIM,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pi_data,
  input  logic       pi_flag,
  output logic       rs232_tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       fifo_full,
  output logic       ovf_flag
);

  localparam int                BAUD_W    = cnt_width(BAUD_END);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_END - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e            state_reg, state_next;
  logic [BAUD_W-1:0]    baud_cnt_reg, baud_cnt_next;
  logic [2:0]           bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 tx_reg, tx_next;
  logic                 tx_done_reg, tx_done_next;
  logic                 tx_busy_reg;
  logic                 ovf_reg;

  logic                 fifo_rd;
  logic                 fifo_empty;
  logic                 fifo_full_w;
  logic [DATA_BITS-1:0] fifo_dout;
  logic [FIFO_AW:0]     fifo_count;
  logic                 baud_last;
  logic                 write_drop;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .AW    (FIFO_AW),
    .DW    (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (pi_flag),
    .din   (pi_data),
    .rd_en (fifo_rd),
    .dout  (fifo_dout),
    .full  (fifo_full_w),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign baud_last  = (baud_cnt_reg == BAUD_LAST);
  assign write_drop = pi_flag && fifo_full_w && !fifo_rd;

  // The FIFO's registered read settles on the pop edge and holds until the next pop,
  // so the byte is captured into the shift register on the way into DATA.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    tx_next       = 1'b1;
    tx_done_next  = 1'b0;
    fifo_rd       = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        baud_cnt_next = '0;
        if (!fifo_empty) begin
          fifo_rd    = 1'b1;
          state_next = TX_START;
        end
      end
      TX_START: begin
        tx_next       = 1'b0;
        baud_cnt_next = baud_last ? '0 : baud_cnt_reg + 1'b1;
        if (baud_last) begin
          state_next   = TX_DATA;
          bit_cnt_next = '0;
          shift_next   = fifo_dout;
        end
      end
      TX_DATA: begin
        tx_next       = shift_reg[bit_cnt_reg];
        baud_cnt_next = baud_last ? '0 : baud_cnt_reg + 1'b1;
        if (baud_last) begin
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = TX_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end
      end
      TX_STOP: begin
        tx_done_next  = baud_last;
        baud_cnt_next = baud_last ? '0 : baud_cnt_reg + 1'b1;
        if (baud_last) begin
          // Chain straight into the next frame when more bytes are waiting.
          if (!fifo_empty) begin
            fifo_rd    = 1'b1;
            state_next = TX_START;
          end else begin
            state_next = TX_IDLE;
          end
        end
      end
      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= TX_IDLE;
      baud_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      tx_reg       <= 1'b1;
      tx_done_reg  <= 1'b0;
      tx_busy_reg  <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      tx_reg       <= tx_next;
      tx_done_reg  <= tx_done_next;
      tx_busy_reg  <= (state_reg != TX_IDLE) || (fifo_count != '0);
      ovf_reg      <= write_drop;
    end
  end

  assign rs232_tx  = tx_reg;
  assign tx_done   = tx_done_reg;
  assign tx_busy   = tx_busy_reg;
  assign fifo_full = fifo_full_w;
  assign ovf_flag  = ovf_reg;

endmodule
